// File: rtl/mac_seq_ctrl_if.sv
// Bundle of the command, operand, MAC and result signals of mac_seq_ctrl.
// The slave modport is the controller's view; master is the surrounding
// environment (operand source, MAC datapath, result consumer).
// Optional feature macro: OVF_FLAG_EN adds the sticky ovf flag.
//
// Handshake semantics (operand stream and result port): a transfer happens
// in a cycle where valid and ready are both high at the rising clock edge.
// A source holding valid keeps its data stable until that transfer; the
// sink may raise or drop ready freely. mac_vld / mac_res_vld are one-cycle
// strobes with no back-pressure.
interface mac_seq_ctrl_if #(
    parameter int LEN_W = 8
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_a;
    logic [15:0]      in_b;
    logic             mac_vld;
    logic [15:0]      mac_a;
    logic [15:0]      mac_b;
    logic [15:0]      mac_c;
    logic [15:0]      mac_res;
    logic             mac_res_vld;
    logic             res_valid;
    logic [15:0]      res_data;
    logic             res_ready;
    logic             err;
`ifdef OVF_FLAG_EN
    logic             ovf;
`endif
    logic [1:0]       dbg_state;

    modport slave (
        input  start, len, in_valid, in_a, in_b, mac_res, mac_res_vld, res_ready,
`ifdef OVF_FLAG_EN
        output ovf,
`endif
        output busy, in_ready, mac_vld, mac_a, mac_b, mac_c,
        output res_valid, res_data, err, dbg_state
    );

    modport master (
        output start, len, in_valid, in_a, in_b, mac_res, mac_res_vld, res_ready,
`ifdef OVF_FLAG_EN
        input  ovf,
`endif
        input  busy, in_ready, mac_vld, mac_a, mac_b, mac_c,
        input  res_valid, res_data, err, dbg_state
    );
endinterface

// File: rtl/mac_seq_ctrl.sv
// Sequencer for a 3-stage FP16 MAC pipeline: runs one dot product of 'len'
// operand pairs per job, one MAC op in flight at a time, feeding the running
// accumulator back as the addend and returning the rounded sum.
// Optional feature macro: OVF_FLAG_EN (sticky Inf/NaN result flag).
// dbg_state exposes the FSM state: 0=IDLE 1=ISSUE 2=WAIT 3=DONE.
module mac_seq_ctrl #(
    parameter int LEN_W    = 8,
    parameter int PIPE_LAT = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    mac_seq_ctrl_if.slave  bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // wcnt counts WAIT cycles from 0; the op times out in the cycle whose
    // increment would bring wcnt to 2*PIPE_LAT+1.
    localparam int              WCNT_W   = $clog2(2 * PIPE_LAT + 1);
    localparam logic [WCNT_W-1:0] TMO_LAST = WCNT_W'(2 * PIPE_LAT);

    logic [1:0]        state_q, state_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [15:0]       acc_q, acc_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [15:0]       mac_a_q, mac_a_d;
    logic [15:0]       mac_b_q, mac_b_d;
    logic [15:0]       mac_c_q, mac_c_d;
    logic              mac_vld_q, mac_vld_d;
    logic              err_q, err_d;
`ifdef OVF_FLAG_EN
    logic              ovf_q, ovf_d;
`endif

    // Next-state and datapath update for the job sequencer.
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        acc_d     = acc_q;
        wcnt_d    = wcnt_q;
        mac_a_d   = mac_a_q;
        mac_b_d   = mac_b_q;
        mac_c_d   = mac_c_q;
        mac_vld_d = 1'b0;
        err_d     = err_q;
`ifdef OVF_FLAG_EN
        ovf_d     = ovf_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    rem_d   = bus.len;
                    acc_d   = 16'h0000;
                    err_d   = 1'b0;
`ifdef OVF_FLAG_EN
                    ovf_d   = 1'b0;
`endif
                    state_d = (bus.len == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (bus.in_valid) begin
                    mac_a_d   = bus.in_a;
                    mac_b_d   = bus.in_b;
                    mac_c_d   = acc_q;
                    mac_vld_d = 1'b1;
                    // rem never wraps below zero.
                    if (rem_q != '0) begin
                        rem_d = rem_q - LEN_W'(1);
                    end
                    wcnt_d  = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.mac_res_vld) begin
                    acc_d   = bus.mac_res;
`ifdef OVF_FLAG_EN
                    if (bus.mac_res[14:10] == 5'b11111) begin
                        ovf_d = 1'b1;
                    end
`endif
                    state_d = (rem_q == '0) ? ST_DONE : ST_ISSUE;
                end else if (wcnt_q == TMO_LAST) begin
                    // MAC never answered: flag it and close the job with
                    // the accumulator left as it was.
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
            end
            ST_DONE: begin
                if (bus.res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rem_q     <= '0;
            acc_q     <= 16'h0000;
            wcnt_q    <= '0;
            mac_a_q   <= 16'h0000;
            mac_b_q   <= 16'h0000;
            mac_c_q   <= 16'h0000;
            mac_vld_q <= 1'b0;
            err_q     <= 1'b0;
`ifdef OVF_FLAG_EN
            ovf_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            acc_q     <= acc_d;
            wcnt_q    <= wcnt_d;
            mac_a_q   <= mac_a_d;
            mac_b_q   <= mac_b_d;
            mac_c_q   <= mac_c_d;
            mac_vld_q <= mac_vld_d;
            err_q     <= err_d;
`ifdef OVF_FLAG_EN
            ovf_q     <= ovf_d;
`endif
        end
    end

    // Output decode: status and handshakes come straight from the state.
    always_comb begin
        bus.busy      = (state_q != ST_IDLE);
        bus.in_ready  = (state_q == ST_ISSUE);
        bus.mac_vld   = mac_vld_q;
        bus.mac_a     = mac_a_q;
        bus.mac_b     = mac_b_q;
        bus.mac_c     = mac_c_q;
        bus.res_valid = (state_q == ST_DONE);
        bus.res_data  = (state_q == ST_DONE) ? acc_q : 16'h0000;
        bus.err       = err_q;
`ifdef OVF_FLAG_EN
        bus.ovf       = ovf_q;
`endif
        bus.dbg_state = state_q;
    end
endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Testbench for mac_seq_ctrl: directed jobs against a PIPE_LAT=3 MAC model
// returning hand-computed a*b+c values; a monitor pops expected MAC issues
// and results from queues. Build with +define+OVF_FLAG_EN for the ovf flag.
module tb_mac_seq_ctrl;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;
    int   suppress_next = 0;

    logic [47:0] exp_mac_q[$];
    logic [16:0] exp_res_q[$];

    mac_seq_ctrl_if #(.LEN_W(8)) bus_if ();

    mac_seq_ctrl #(.LEN_W(8), .PIPE_LAT(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- MAC model (hand-computed FP16 a*b+c) ----------------
    function automatic logic [15:0] mac_model(input logic [15:0] a, b, c);
        case ({a, b, c})
            {16'h3C00, 16'h4000, 16'h0000}: return 16'h4000; // 1*2+0 = 2
            {16'h3C00, 16'h3C00, 16'h4000}: return 16'h4200; // 1*1+2 = 3
            {16'h4000, 16'h3800, 16'h4200}: return 16'h4400; // 2*0.5+3 = 4
            {16'h4000, 16'h4000, 16'h0000}: return 16'h4400; // 2*2+0 = 4
            {16'h3C00, 16'h3800, 16'h4400}: return 16'h4480; // 1*0.5+4 = 4.5
            {16'h7BFF, 16'h4000, 16'h0000}: return 16'h7C00; // 65504*2 -> +Inf
            default:                        return 16'h1234;
        endcase
    endfunction

    logic        pv [3];
    logic [15:0] pd [3];
    initial begin
        for (int i = 0; i < 3; i++) begin
            pv[i] = 1'b0;
            pd[i] = 16'h0000;
        end
        bus_if.mac_res_vld = 1'b0;
        bus_if.mac_res     = 16'h0000;
        forever begin
            @(negedge clk);
            // Value for this cycle first, then shift in this cycle's issue:
            // a mac_vld in cycle k answers in cycle k+3.
            bus_if.mac_res_vld = pv[2];
            bus_if.mac_res     = pd[2];
            pv[2] = pv[1]; pd[2] = pd[1];
            pv[1] = pv[0]; pd[1] = pd[0];
            pv[0] = 1'b0;
            pd[0] = 16'h0000;
            if (bus_if.mac_vld === 1'b1) begin
                pd[0] = mac_model(bus_if.mac_a, bus_if.mac_b, bus_if.mac_c);
                pv[0] = (suppress_next == 0);
                suppress_next = 0;
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus_if.mac_vld === 1'b1) begin
            if (exp_mac_q.size() == 0) begin
                check("mac_unexpected", 32'(bus_if.mac_vld), 32'h0);
            end else begin
                check("mac_abc", {16'h0, 16'h0} | 32'(0), 32'(0));
                n_checks--;
                check("mac_op", 32'({bus_if.mac_a, bus_if.mac_b} ^ exp_mac_q[0][47:16]), 32'h0);
                check("mac_c", 32'(bus_if.mac_c), 32'(exp_mac_q[0][15:0]));
                void'(exp_mac_q.pop_front());
            end
        end
        if (rst_n === 1'b1 && bus_if.res_valid === 1'b1 && bus_if.res_ready === 1'b1) begin
            if (exp_res_q.size() == 0) begin
                check("res_unexpected", 32'(bus_if.res_valid), 32'h0);
            end else begin
                check("res_data", 32'(bus_if.res_data), 32'(exp_res_q[0][15:0]));
                check("res_err", 32'(bus_if.err), 32'(exp_res_q[0][16]));
                void'(exp_res_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_job(input logic [7:0] l);
        bus_if.start = 1'b1;
        bus_if.len   = l;
        step();
        bus_if.start = 1'b0;
    endtask

    // Returns in the cycle after the handshake (the mac_vld cycle).
    task automatic send_pair(input logic [15:0] a, b, exp_c, input int gap);
        bit done = 0;
        bus_if.in_valid = 1'b0;
        for (int i = 0; i < gap; i++) step();
        bus_if.in_valid = 1'b1;
        bus_if.in_a     = a;
        bus_if.in_b     = b;
        for (int i = 0; i < 50 && !done; i++) begin
            if (bus_if.in_ready === 1'b1) begin
                exp_mac_q.push_back({a, b, exp_c});
                done = 1;
            end
            step();
        end
        bus_if.in_valid = 1'b0;
        if (!done) check("in_ready_timeout", 32'h0, 32'h1);
        else       check("mac_vld_pulse", 32'(bus_if.mac_vld), 32'h1);
    endtask

    task automatic collect(input logic [15:0] exp_data, input logic exp_err,
                           input int hold, input bit poke_start);
        bit seen = 0;
        exp_res_q.push_back({exp_err, exp_data});
        for (int i = 0; i < 50 && !seen; i++) begin
            if (bus_if.res_valid === 1'b1) seen = 1;
            else step();
        end
        if (!seen) begin
            check("res_valid_timeout", 32'h0, 32'h1);
            void'(exp_res_q.pop_back());
            return;
        end
        for (int i = 0; i < hold; i++) begin
            if (poke_start && i == 1) begin
                bus_if.start = 1'b1;
                bus_if.len   = 8'd5;
            end
            step();
            bus_if.start = 1'b0;
            check("hold_valid", 32'(bus_if.res_valid), 32'h1);
            check("hold_data", 32'(bus_if.res_data), 32'(exp_data));
            check("hold_busy", 32'(bus_if.busy), 32'h1);
            check("hold_state", 32'(bus_if.dbg_state), 32'(ST_DONE));
        end
        bus_if.res_ready = 1'b1;
        step();
        bus_if.res_ready = 1'b0;
        check("post_hs_state", 32'(bus_if.dbg_state), 32'(ST_IDLE));
        check("post_hs_valid", 32'(bus_if.res_valid), 32'h0);
        check("post_hs_busy", 32'(bus_if.busy), 32'h0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_state"}, 32'(bus_if.dbg_state), 32'(ST_IDLE));
        check({tag, "_busy"}, 32'(bus_if.busy), 32'h0);
        check({tag, "_in_ready"}, 32'(bus_if.in_ready), 32'h0);
        check({tag, "_mac_vld"}, 32'(bus_if.mac_vld), 32'h0);
        check({tag, "_mac_abc"}, 32'({bus_if.mac_a, bus_if.mac_b} | 32'(bus_if.mac_c)), 32'h0);
        check({tag, "_res_valid"}, 32'(bus_if.res_valid), 32'h0);
        check({tag, "_res_data"}, 32'(bus_if.res_data), 32'h0);
        check({tag, "_err"}, 32'(bus_if.err), 32'h0);
`ifdef OVF_FLAG_EN
        check({tag, "_ovf"}, 32'(bus_if.ovf), 32'h0);
`endif
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_n            = 1'b0;
        bus_if.start     = 1'b0;
        bus_if.len       = 8'd0;
        bus_if.in_valid  = 1'b0;
        bus_if.in_a      = 16'h0000;
        bus_if.in_b      = 16'h0000;
        bus_if.res_ready = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        check_all_zero("reset");

        // 1: three-pair dot product 1*2 + 1*1 + 2*0.5 = 4
        start_job(8'd3);
        send_pair(16'h3C00, 16'h4000, 16'h0000, 0);
        send_pair(16'h3C00, 16'h3C00, 16'h4000, 0);
        send_pair(16'h4000, 16'h3800, 16'h4200, 0);
        collect(16'h4400, 1'b0, 0, 0);

        // 2: empty job goes straight to DONE
        start_job(8'd0);
        check("len0_valid", 32'(bus_if.res_valid), 32'h1);
        check("len0_data", 32'(bus_if.res_data), 32'h0);
        collect(16'h0000, 1'b0, 0, 0);

        // 3: operand gaps, consumer stall, ignored start during DONE
        start_job(8'd2);
        send_pair(16'h4000, 16'h4000, 16'h0000, 4);
        send_pair(16'h3C00, 16'h3800, 16'h4400, 4);
        collect(16'h4480, 1'b0, 5, 1);
        step();
        check("ignored_start_idle", 32'(bus_if.busy), 32'h0);

        // 4: MAC drops the result -> timeout seven cycles after mac_vld
        start_job(8'd1);
        suppress_next = 1;
        send_pair(16'h3C00, 16'h4000, 16'h0000, 0);
        repeat (6) step();
        check("tmo_err_early", 32'(bus_if.err), 32'h0);
        step();
        check("tmo_err", 32'(bus_if.err), 32'h1);
        check("tmo_valid", 32'(bus_if.res_valid), 32'h1);
        collect(16'h0000, 1'b1, 0, 0);

        // 5: reset during WAIT, late MAC result ignored
        start_job(8'd1);
        check("start_clears_err", 32'(bus_if.err), 32'h0);
        send_pair(16'h4000, 16'h4000, 16'h0000, 0);
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_all_zero("midjob_rst");
        step();
        step();
        check_all_zero("after_late_res");
        check("acc_after_rst", 32'(dut.acc_q), 32'h0);

        // 6: overflow to +Inf
        start_job(8'd1);
        send_pair(16'h7BFF, 16'h4000, 16'h0000, 0);
        repeat (4) step();
        check("ovf_res_data", 32'(bus_if.res_data), 32'h7C00);
`ifdef OVF_FLAG_EN
        check("ovf_set", 32'(bus_if.ovf), 32'h1);
`endif
        collect(16'h7C00, 1'b0, 0, 0);
        start_job(8'd0);
`ifdef OVF_FLAG_EN
        check("ovf_cleared", 32'(bus_if.ovf), 32'h0);
`endif
        collect(16'h0000, 1'b0, 0, 0);

        repeat (3) step();
        check("mac_q_empty", 32'(exp_mac_q.size()), 32'h0);
        check("res_q_empty", 32'(exp_res_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
